delay_req_scheduler: RTL and testbench



---
 rtl/delay_req_scheduler_pkg.sv | 21 ++
 rtl/delay_req_scheduler_if.sv | 39 +++
 rtl/delay_req_scheduler_sync_fifo.sv | 73 +++++++
 rtl/delay_req_scheduler.sv | 98 +++++++++
 tb/tb_delay_req_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_req_scheduler_pkg.sv
// delay_sched_pkg: shared types and widths for the delay request scheduler.
//   DELAY_W     - width of a delay request (clock periods)
//   TAG_WIDTH   - caller tag width; the scheduler's TAG_W must equal this
//   delay_req_t - one FIFO entry: {delay, tag}
//   occ_width() - width of an occupancy count for a FIFO of a given depth
package delay_sched_pkg;

    localparam int DELAY_W   = 8;
    localparam int TAG_WIDTH = 4;

    typedef struct packed {
        logic [DELAY_W-1:0]   delay;
        logic [TAG_WIDTH-1:0] tag;
    } delay_req_t;

    // A count must hold 0..depth inclusive, hence one bit more than the pointer.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/delay_req_scheduler_if.sv
// delay_req_scheduler_if: request port, counter-facing port and status of the
// delay request scheduler bundled together.
//   req_*       - ready/valid request channel (delay + tag)
//   counter_*   - issue strobe/value towards the delay counter and its idle flag
//   done_*      - one-cycle completion pulse with the finished tag
//   occupancy   - FIFO entry count
//   busy        - a request is in flight in the counter
// Modports: slave = scheduler side, master = requester/counter side.
interface delay_req_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    import delay_sched_pkg::*;

    logic                   req_vld;
    logic                   req_rdy;
    logic [DELAY_W-1:0]     req_delay;
    logic [TAG_W-1:0]       req_tag;
    logic [DELAY_W-1:0]     counter_until_this;
    logic                   counter_vld;
    logic                   counter_reached;
    logic                   done_vld;
    logic [TAG_W-1:0]       done_tag;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   busy;

    modport slave (
        input  req_vld, req_delay, req_tag, counter_reached,
        output req_rdy, counter_until_this, counter_vld,
               done_vld, done_tag, occupancy, busy
    );

    modport master (
        output req_vld, req_delay, req_tag, counter_reached,
        input  req_rdy, counter_until_this, counter_vld,
               done_vld, done_tag, occupancy, busy
    );

endinterface

// File: rtl/delay_req_scheduler_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-high reset.
//   clk, rst  - clock / synchronous reset (pointers and count cleared)
//   push_i    - write din_i at the tail; ignored while full
//   pop_i     - drop the head entry; ignored while empty
//   din_i     - entry to write
//   full_o    - count == DEPTH
//   empty_o   - count == 0
//   count_o   - number of stored entries (registered)
//   head_o    - entry at the head (meaningless while empty)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       din_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output T                       head_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full/empty gating lives here so a careless caller cannot corrupt state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/delay_req_scheduler.sv
// delay_req_scheduler: queues tagged delay requests and feeds them one at a
// time to a ready/valid delay counter, reporting each completion with its tag.
//   clk, rst - clock / synchronous active-high reset (shared with the counter)
//   bus      - delay_req_scheduler_if.slave:
//              req_vld/req_rdy/req_delay/req_tag   request channel
//              counter_until_this/counter_vld      issue towards the counter
//              counter_reached                     counter idle/expired
//              done_vld/done_tag                   registered completion pulse
//              occupancy, busy                     registered status
// TAG_W must equal delay_sched_pkg::TAG_WIDTH since FIFO entries use that type.
module delay_req_scheduler
    import delay_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    delay_req_scheduler_if.slave  bus
);
    localparam int CNT_W = occ_width(DEPTH);

    delay_req_t       push_data;
    delay_req_t       head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push, issue, complete;

    logic             busy_q,         busy_d;
    logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
    logic             done_vld_q,     done_vld_d;
    logic [TAG_W-1:0] done_tag_q,     done_tag_d;

    // Ready depends only on the registered count, so a pop on the same edge
    // never frees a slot for the push (no push-through).
    assign push      = bus.req_vld && !fifo_full;
    assign push_data = {bus.req_delay, bus.req_tag};

    // The head goes to the counter whenever the FIFO holds something; the
    // counter takes it at the edge where it also reports itself idle.
    assign issue    = !fifo_empty && bus.counter_reached;
    assign complete = busy_q && bus.counter_reached;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (delay_req_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (issue),
        .din_i   (push_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head)
    );

    always_comb begin
        busy_d         = busy_q;
        inflight_tag_d = inflight_tag_q;
        done_vld_d     = complete;
        done_tag_d     = done_tag_q;
        if (complete) begin
            busy_d     = 1'b0;
            done_tag_d = inflight_tag_q;
        end
        // Issue after complete: on a back-to-back edge the old tag has already
        // been copied to done_tag and busy stays set for the new request.
        if (issue) begin
            busy_d         = 1'b1;
            inflight_tag_d = head.tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= 1'b0;
            inflight_tag_q <= '0;
            done_vld_q     <= 1'b0;
            done_tag_q     <= '0;
        end else begin
            busy_q         <= busy_d;
            inflight_tag_q <= inflight_tag_d;
            done_vld_q     <= done_vld_d;
            done_tag_q     <= done_tag_d;
        end
    end

    assign bus.req_rdy            = !fifo_full;
    assign bus.counter_vld        = !fifo_empty;
    assign bus.counter_until_this = fifo_empty ? '0 : head.delay;
    assign bus.done_vld           = done_vld_q;
    assign bus.done_tag           = done_tag_q;
    assign bus.occupancy          = fifo_count;
    assign bus.busy               = busy_q;

endmodule

// File: tb/tb_delay_req_scheduler.sv
module tb_delay_req_scheduler;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    delay_req_scheduler_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) ifc ();

    delay_req_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Behavioural delay counter: after an issue of N, reached rises N edges
    // later; N=0 leaves it high.
    logic cnt_reached = 1'b1;
    int   cnt_rem     = 0;
    assign ifc.counter_reached = cnt_reached;

    always @(posedge clk) begin
        if (rst) begin
            cnt_reached <= 1'b1;
            cnt_rem     <= 0;
        end else if (ifc.counter_vld && cnt_reached) begin
            if (ifc.counter_until_this != 0) begin
                cnt_reached <= 1'b0;
                cnt_rem     <= int'(ifc.counter_until_this);
            end
        end else if (!cnt_reached) begin
            if (cnt_rem == 1) cnt_reached <= 1'b1;
            cnt_rem <= cnt_rem - 1;
        end
    end

    // Scoreboard: on acceptance predict the completion edge. A request issues
    // one edge after acceptance or at the previous completion edge, whichever
    // is later, and completes N+1 edges after issue.
    typedef struct {
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   last_c = 0;
    int   dcyc[$];
    int   dtags[$];

    always @(posedge clk) begin
        int iss;
        cyc = cyc + 1;
        if (rst) begin
            sb.delete();
            last_c = 0;
        end else if (ifc.req_vld && ifc.req_rdy) begin
            iss    = (cyc + 1 > last_c) ? cyc + 1 : last_c;
            last_c = iss + int'(ifc.req_delay) + 1;
            sb.push_back('{ifc.req_tag, last_c});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.done_vld) begin
            dcyc.push_back(cyc);
            dtags.push_back(int'(ifc.done_tag));
            if (sb.size() == 0) begin
                check("unexpected_done", ifc.done_vld, 0);
            end else begin
                e = sb.pop_front();
                check("sb_done_tag", ifc.done_tag, e.tag);
                check("sb_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic [TAG_W-1:0] t, output int acc);
        int w = 0;
        ifc.req_vld   = 1'b1;
        ifc.req_delay = d;
        ifc.req_tag   = t;
        @(negedge clk);
        while (!ifc.req_rdy && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("push_rdy_wait", ifc.req_rdy, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        ifc.req_vld = 1'b0;
    endtask

    task automatic drain(input string nm);
        int w = 0;
        while (sb.size() != 0 && w < 2000) begin
            w++;
            @(negedge clk);
        end
        check(nm, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]       delay;
        logic [TAG_W-1:0] tag;
        int               exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int acc, a0, pop_cyc, dc, w, nd;
        int accs[4];

        vecs[0] = '{8'd0,   4'd1,  2};
        vecs[1] = '{8'd3,   4'd2,  5};
        vecs[2] = '{8'd1,   4'd11, 3};
        vecs[3] = '{8'd7,   4'd15, 9};
        vecs[4] = '{8'd255, 4'd0,  257};

        ifc.req_vld   = 1'b0;
        ifc.req_delay = '0;
        ifc.req_tag   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_rdy",   ifc.req_rdy, 1);
        check("rst_cnt_vld",   ifc.counter_vld, 0);
        check("rst_until",     ifc.counter_until_this, 0);
        check("rst_done_vld",  ifc.done_vld, 0);
        check("rst_done_tag",  ifc.done_tag, 0);
        check("rst_occupancy", ifc.occupancy, 0);
        check("rst_busy",      ifc.busy, 0);
        @(posedge clk);
        #1;

        // Single requests with an idle counter: latency N+2, one-cycle pulse
        foreach (vecs[i]) begin
            push(vecs[i].delay, vecs[i].tag, acc);
            w = 0;
            @(negedge clk);
            while (!ifc.done_vld && w < 400) begin
                w++;
                @(negedge clk);
            end
            check("vec_done_seen", ifc.done_vld, 1);
            check("vec_latency",   cyc - acc, vecs[i].exp_lat);
            check("vec_done_tag",  ifc.done_tag, vecs[i].tag);
            check("vec_busy_fall", ifc.busy, 0);
            @(negedge clk);
            check("vec_pulse_len", ifc.done_vld, 0);
            @(posedge clk);
            #1;
        end

        // Back-to-back queue: delays 3,0,5,1 tags 3..6
        dcyc.delete();
        dtags.delete();
        push(8'd3, 4'd3, accs[0]);
        push(8'd0, 4'd4, accs[1]);
        push(8'd5, 4'd5, accs[2]);
        push(8'd1, 4'd6, accs[3]);
        for (int i = 1; i < 4; i++) check("b2b_accept_consec", accs[i] - accs[0], i);
        drain("b2b_drain");
        check("b2b_n_done", dcyc.size(), 4);
        if (dcyc.size() == 4) begin
            check("b2b_first_lat", dcyc[0] - accs[0], 5);
            check("b2b_gap1", dcyc[1] - dcyc[0], 1);
            check("b2b_gap2", dcyc[2] - dcyc[1], 6);
            check("b2b_gap3", dcyc[3] - dcyc[2], 2);
            for (int i = 0; i < 4; i++) check("b2b_tag_order", dtags[i], 3 + i);
        end
        @(posedge clk);
        #1;

        // Full FIFO behind an in-flight delay of 10
        push(8'd10, 4'd1, a0);
        push(8'd2,  4'd2, acc);
        push(8'd0,  4'd3, acc);
        push(8'd1,  4'd4, acc);
        push(8'd3,  4'd5, acc);
        @(negedge clk);
        check("full_occ",     ifc.occupancy, 4);
        check("full_req_rdy", ifc.req_rdy, 0);
        ifc.req_vld   = 1'b1;
        ifc.req_delay = 8'd0;
        ifc.req_tag   = 4'd6;
        w = 0;
        while (!ifc.req_rdy && w < 50) begin
            check("full_occ_max", (ifc.occupancy <= 4), 1);
            w++;
            @(negedge clk);
        end
        pop_cyc = cyc;
        check("full_pop_edge",      pop_cyc - a0, 12);
        check("full_no_pushthru",   ifc.occupancy, 3);
        @(posedge clk);
        #1 ifc.req_vld = 1'b0;
        @(negedge clk);
        check("full_late_accept",   ifc.occupancy, 4);
        drain("full_drain");
        @(posedge clk);
        #1;

        // Reset in the middle of a long delay
        push(8'd20, 4'd7, acc);
        push(8'd1,  4'd8, acc);
        push(8'd2,  4'd9, acc);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_occupancy", ifc.occupancy, 0);
        check("mrst_busy",      ifc.busy, 0);
        check("mrst_cnt_vld",   ifc.counter_vld, 0);
        check("mrst_until",     ifc.counter_until_this, 0);
        check("mrst_req_rdy",   ifc.req_rdy, 1);
        check("mrst_done_vld",  ifc.done_vld, 0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifc.done_vld) nd++;
        end
        check("mrst_no_done", nd, 0);
        @(posedge clk);
        #1;

        // Pointer wrap: 10 delay=1 requests
        dtags.delete();
        for (int i = 0; i < 10; i++) push(8'd1, 4'(i % 16), acc);
        drain("wrap_drain");
        dc = dtags.size();
        check("wrap_n_done", dc, 10);
        if (dc == 10) begin
            for (int i = 0; i < 10; i++) check("wrap_tag", dtags[i], i % 16);
        end
        check("wrap_occ_end", ifc.occupancy, 0);
        check("wrap_busy_end", ifc.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
